// File: rtl/median_ram_reader.sv
// median_ram_reader: walks a wrap-around RAM address window and streams the words out over valid/ready.
// Define MEDIAN_RAM_RD_LAST_EN to add an m_last flag on the final word of each window.
module median_ram_reader #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
`ifdef MEDIAN_RAM_RD_LAST_EN
    output logic                  m_last,
`endif
    input  logic                  m_ready
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t                state;
    logic [ADDR_WIDTH:0]   remaining;
    logic                  inflight;
    logic [DATA_WIDTH-1:0] buf_data [2];
    logic                  rd_ptr, wr_ptr;
    logic [1:0]            buf_count;
    logic                  pop, issue, finish;
`ifdef MEDIAN_RAM_RD_LAST_EN
    logic                  inflight_last;
    logic [1:0]            buf_last;
    assign m_last = m_valid & buf_last[rd_ptr];
`endif
    assign m_valid = buf_count != 2'd0;
    assign m_data  = buf_data[rd_ptr];
    assign pop     = m_valid & m_ready;
    // A read in flight always has a free slot reserved, so capture never overflows.
    assign issue   = state == RUN && remaining != '0 && (buf_count + 2'(inflight) - 2'(pop)) < 2'd2;
    // Finish one cycle after the last handshake, counting the pop happening now.
    assign finish  = state == DRAIN && !inflight && buf_count == 2'(pop);
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state       <= IDLE;
            remaining   <= '0;
            inflight    <= 1'b0;
            buf_data[0] <= '0;
            buf_data[1] <= '0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            buf_count   <= 2'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            ram_rd_addr <= '0;
`ifdef MEDIAN_RAM_RD_LAST_EN
            inflight_last <= 1'b0;
            buf_last      <= 2'b00;
`endif
        end else begin
            done      <= 1'b0;
            inflight  <= issue;
            buf_count <= buf_count + 2'(inflight) - 2'(pop);
            if (inflight) begin
                buf_data[wr_ptr] <= ram_rd_data;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
`ifdef MEDIAN_RAM_RD_LAST_EN
            inflight_last <= issue && remaining == (ADDR_WIDTH+1)'(1);
            if (inflight) buf_last[wr_ptr] <= inflight_last;
`endif
            case (state)
                IDLE: if (start) begin
                    if (length == '0) begin
                        done <= 1'b1;
                    end else begin
                        ram_rd_addr <= start_addr;
                        remaining   <= length;
                        busy        <= 1'b1;
                        state       <= RUN;
                    end
                end
                RUN: if (issue) begin
                    remaining <= remaining - (ADDR_WIDTH+1)'(1);
                    // Keep the final issued address on the port once the window is exhausted.
                    if (remaining == (ADDR_WIDTH+1)'(1)) state <= DRAIN;
                    else ram_rd_addr <= ram_rd_addr + ADDR_WIDTH'(1);
                end
                DRAIN: if (finish) begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_median_ram_reader.sv
// tb_median_ram_reader: directed checks of the RAM read streamer against a mem[a]=a RAM model.
module tb_median_ram_reader;
    logic        rd_clk = 1'b0, rd_rst = 1'b1, start = 1'b0, m_ready = 1'b1;
    logic [9:0]  start_addr = '0;
    logic [10:0] length = '0;
    logic        busy, done, m_valid;
    logic [9:0]  ram_rd_addr;
    logic [63:0] ram_rd_data, m_data;
    logic [63:0] mem [1024];
    int          checks = 0, errors = 0;
`ifdef MEDIAN_RAM_RD_LAST_EN
    logic        m_last;
`endif

    median_ram_reader dut (
        .rd_clk(rd_clk), .rd_rst(rd_rst), .start(start), .start_addr(start_addr), .length(length),
        .busy(busy), .done(done), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
        .m_data(m_data), .m_valid(m_valid),
`ifdef MEDIAN_RAM_RD_LAST_EN
        .m_last(m_last),
`endif
        .m_ready(m_ready)
    );

    always #5 rd_clk = ~rd_clk;
    always_ff @(posedge rd_clk) ram_rd_data <= mem[ram_rd_addr];

    initial for (int i = 0; i < 1024; i++) mem[i] = 64'(i);

    task automatic pulse_start(input logic [9:0] a, input logic [10:0] l);
        @(negedge rd_clk);
        start = 1'b1; start_addr = a; length = l;
        @(posedge rd_clk);
        #1 start = 1'b0;
    endtask

    // Observes one window; cycle 1 is the cycle right after the start edge.
    task automatic stream(input logic [9:0] base, input int max_cyc, input int stop_after, input bit rnd,
                          output int words, output int bad, output int unstable, output bit got_done,
                          output int first_cyc, output int done_cyc, output logic [63:0] last_data,
                          output int lasts, output bit last_final);
        logic        pv = 1'b0, pr = 1'b0;
        logic [63:0] pd = '0;
        logic [9:0]  ea;
        words = 0; bad = 0; unstable = 0; got_done = 1'b0; first_cyc = -1; done_cyc = -1;
        last_data = '0; lasts = 0; last_final = 1'b0;
        for (int cyc = 1; cyc <= max_cyc; cyc++) begin
            @(negedge rd_clk);
            if (pv && !pr && (!m_valid || m_data !== pd)) unstable++;
            if (m_valid && first_cyc < 0) first_cyc = cyc;
            if (m_valid && m_ready) begin
                ea = base + 10'(words);
                if (m_data !== 64'(ea)) bad++;
                last_data = m_data;
`ifdef MEDIAN_RAM_RD_LAST_EN
                lasts += int'(m_last);
                last_final = m_last;
`endif
                words++;
                if (words == stop_after) break;
            end
            pv = m_valid; pr = m_ready; pd = m_data;
            if (done) begin
                got_done = 1'b1;
                done_cyc = cyc;
                break;
            end
            @(posedge rd_clk);
            #1 if (rnd) m_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic test_reset;
        @(negedge rd_clk);
        checks++;
        if ({busy, done, m_valid, m_data, ram_rd_addr} !== '0) begin
            errors++;
            $display("FAIL reset_values: busy=%b done=%b m_valid=%b m_data=%h addr=%h, want all 0",
                     busy, done, m_valid, m_data, ram_rd_addr);
        end
        rd_rst = 1'b0;
    endtask

    task automatic test_basic;
        m_ready = 1'b1;
        pulse_start(10'h010, 11'd4);
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge rd_clk);
            if (cyc == 1) begin
                checks++;
                if (ram_rd_addr !== 10'h010) begin
                    errors++; $display("FAIL basic_addr: got %h want 010", ram_rd_addr);
                end
            end
            checks++;
            if (busy !== (cyc <= 6) || done !== (cyc == 7) || m_valid !== (cyc >= 3 && cyc <= 6)) begin
                errors++;
                $display("FAIL basic_ctrl cycle %0d: busy=%b done=%b m_valid=%b, want %b %b %b", cyc,
                         busy, done, m_valid, cyc <= 6, cyc == 7, cyc >= 3 && cyc <= 6);
            end
            if (cyc >= 3 && cyc <= 6) begin
                checks++;
                if (m_data !== 64'(16 + cyc - 3)) begin
                    errors++; $display("FAIL basic_data cycle %0d: got %h want %h", cyc, m_data, 16 + cyc - 3);
                end
            end
        end
    endtask

    task automatic test_wrap;
        logic [9:0] want [4] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
        m_ready = 1'b1;
        pulse_start(10'h3FE, 11'd4);
        for (int cyc = 1; cyc <= 7; cyc++) begin
            @(negedge rd_clk);
            if (cyc <= 4) begin
                checks++;
                if (ram_rd_addr !== want[cyc-1]) begin
                    errors++; $display("FAIL wrap_addr cycle %0d: got %h want %h", cyc, ram_rd_addr, want[cyc-1]);
                end
            end
            if (cyc >= 3 && cyc <= 6) begin
                checks++;
                if (!m_valid || m_data !== 64'(want[cyc-3])) begin
                    errors++; $display("FAIL wrap_data cycle %0d: valid=%b got %h want %h", cyc, m_valid, m_data, want[cyc-3]);
                end
            end
            if (cyc == 7) begin
                checks++;
                if (done !== 1'b1) begin errors++; $display("FAIL wrap_done: got %b want 1", done); end
            end
        end
    endtask

    task automatic test_backpressure;
        int w, b, u, f, d, l; bit g, lf; logic [63:0] ld;
        m_ready = 1'b0;
        pulse_start(10'h0A0, 11'd16);
        stream(10'h0A0, 400, 0, 1'b1, w, b, u, g, f, d, ld, l, lf);
        m_ready = 1'b1;
        checks++;
        if (w != 16 || b != 0 || !g) begin
            errors++; $display("FAIL bp_stream: words=%0d bad=%0d done=%b, want 16 0 1", w, b, g);
        end
        checks++;
        if (u != 0) begin errors++; $display("FAIL bp_stable: unstable=%0d want 0", u); end
`ifdef MEDIAN_RAM_RD_LAST_EN
        checks++;
        if (l != 1 || !lf) begin errors++; $display("FAIL bp_last: count=%0d final=%b want 1 1", l, lf); end
`endif
    endtask

    task automatic test_edge_lengths;
        int w, b, u, f, d, l; bit g, lf; logic [63:0] ld;
        m_ready = 1'b1;
        pulse_start(10'h055, 11'd0);
        @(negedge rd_clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || m_valid !== 1'b0) begin
            errors++; $display("FAIL len0_cycle1: done=%b busy=%b valid=%b want 1 0 0", done, busy, m_valid);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge rd_clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || m_valid !== 1'b0) begin
                errors++; $display("FAIL len0_idle: done=%b busy=%b valid=%b want 0 0 0", done, busy, m_valid);
            end
        end
        pulse_start(10'h200, 11'd1024);
        stream(10'h200, 1200, 0, 1'b0, w, b, u, g, f, d, ld, l, lf);
        checks++;
        if (w != 1024 || b != 0 || !g || ld !== 64'h1FF) begin
            errors++; $display("FAIL len1024: words=%0d bad=%0d done=%b last=%h want 1024 0 1 1ff", w, b, g, ld);
        end
    endtask

    task automatic test_commands;
        int w, b, u, f, d, l; bit g, lf; logic [63:0] ld;
        m_ready = 1'b1;
        pulse_start(10'h020, 11'd3);
        @(negedge rd_clk);
        start = 1'b1; start_addr = 10'h100; length = 11'd5;
        @(posedge rd_clk);
        #1 start = 1'b0;
        stream(10'h020, 50, 0, 1'b0, w, b, u, g, f, d, ld, l, lf);
        checks++;
        if (w != 3 || b != 0 || !g || busy !== 1'b0) begin
            errors++; $display("FAIL ignore_busy_start: words=%0d bad=%0d done=%b busy=%b want 3 0 1 0", w, b, g, busy);
        end
        start = 1'b1; start_addr = 10'h040; length = 11'd2;
        @(posedge rd_clk);
        #1 start = 1'b0;
        stream(10'h040, 50, 0, 1'b0, w, b, u, g, f, d, ld, l, lf);
        checks++;
        if (w != 2 || b != 0 || f != 3 || d != 5) begin
            errors++; $display("FAIL start_in_done: words=%0d bad=%0d first=%0d done=%0d want 2 0 3 5", w, b, f, d);
        end
    endtask

    task automatic test_midreset;
        int w, b, u, f, d, l; bit g, lf; logic [63:0] ld;
        m_ready = 1'b1;
        pulse_start(10'h000, 11'd10);
        stream(10'h000, 50, 5, 1'b0, w, b, u, g, f, d, ld, l, lf);
        checks++;
        if (w != 5 || b != 0) begin errors++; $display("FAIL midreset_pre: words=%0d bad=%0d want 5 0", w, b); end
        rd_rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, m_valid, m_data, ram_rd_addr} !== '0) begin
            errors++;
            $display("FAIL midreset_values: busy=%b done=%b m_valid=%b m_data=%h addr=%h, want all 0",
                     busy, done, m_valid, m_data, ram_rd_addr);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge rd_clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL midreset_hold: done=%b busy=%b want 0 0", done, busy);
            end
        end
        rd_rst = 1'b0;
        pulse_start(10'h010, 11'd2);
        stream(10'h010, 50, 0, 1'b0, w, b, u, g, f, d, ld, l, lf);
        checks++;
        if (w != 2 || b != 0 || f != 3 || d != 5) begin
            errors++; $display("FAIL post_reset_run: words=%0d bad=%0d first=%0d done=%0d want 2 0 3 5", w, b, f, d);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_wrap;
        test_backpressure;
        test_edge_lengths;
        test_commands;
        test_midreset;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
